// File: rtl/timer_apb_slave_if.sv
// APB3 bus bundle between a CPU-side requester and the timer register block.
// The requester drives select/enable/address/data; the completer returns read data, ready and error.
interface timer_apb_slave_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/timer_apb_slave.sv
// APB3 completer for the timer TDR/TCR/TSR registers; completes WAIT_CYCLES+1 cycles after SETUP.
// Backpressure via registered pready; dropping psel mid-transfer abandons it without a commit.
module timer_apb_slave #(
    parameter int WAIT_CYCLES = 0,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8
) (
    input  logic             pclk,
    input  logic             prst,
    timer_apb_slave_if.slave apb,
    input  logic             ovf_set,
    input  logic             udf_set,
    output logic [7:0]       tdr,
    output logic             tcr_load,
    output logic [1:0]       tcr_cks,
    output logic             tcr_dn,
    output logic             tcr_en,
    output logic             irq
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam logic [3:0]        WAIT_LD = 4'(WAIT_CYCLES);
    localparam logic [ADDR_W-1:0] A_TDR   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_TCR   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_TSR   = ADDR_W'(2);

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic              r_pready, w_pready_nxt;
    logic              r_pslverr;
    logic [DATA_W-1:0] r_prdata;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [7:0]        r_wdata;
    logic [7:0]        r_tdr;
    logic [7:0]        r_tcr;
    logic [1:0]        r_tsr;
    logic              w_capture;
    logic              w_commit;
    logic [ADDR_W-1:0] w_rsp_addr;
    logic              w_rsp_write;
    logic              w_rsp_err;
    logic [DATA_W-1:0] w_rd_dat;
    logic [1:0]        w_tsr_clr;

    always_ff @(posedge pclk) begin
        if (prst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_pready_nxt = 1'b0;
        w_capture    = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (apb.psel && !apb.penable) w_state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                if (!apb.psel) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_capture    = 1'b1;
                    w_cnt_nxt    = WAIT_LD;
                    w_pready_nxt = (WAIT_LD == 4'd0);
                    w_state_nxt  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!apb.psel) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (r_pready && apb.penable) begin
                    w_commit    = r_write && (r_addr <= A_TSR);
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt != 4'd0) begin
                    w_cnt_nxt    = r_cnt - 4'd1;
                    w_pready_nxt = (r_cnt == 4'd1);
                end else begin
                    w_pready_nxt = r_pready;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // With zero wait states the response is formed on the capture edge, so use the live bus address.
    assign w_rsp_addr  = (r_state == ST_SETUP) ? apb.paddr : r_addr;
    assign w_rsp_write = (r_state == ST_SETUP) ? apb.pwrite : r_write;
    assign w_rsp_err   = (w_rsp_addr > A_TSR);

    always_comb begin
        w_rd_dat = '0;
        case (w_rsp_addr)
            A_TDR:   w_rd_dat = r_tdr;
            A_TCR:   w_rd_dat = r_tcr;
            A_TSR:   w_rd_dat = {6'b0, r_tsr};
            default: w_rd_dat = '0;
        endcase
    end

    assign w_tsr_clr = (w_commit && r_addr == A_TSR) ? r_wdata[1:0] : 2'b00;

    always_ff @(posedge pclk) begin
        if (prst) begin
            r_cnt     <= 4'd0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_wdata   <= 8'h00;
            r_tdr     <= 8'h00;
            r_tcr     <= 8'h00;
            r_tsr     <= 2'b00;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_pready  <= w_pready_nxt;
            r_pslverr <= w_pready_nxt && w_rsp_err;
            r_prdata  <= (w_pready_nxt && !w_rsp_err && !w_rsp_write) ? w_rd_dat : '0;
            if (w_capture) begin
                r_addr  <= apb.paddr;
                r_write <= apb.pwrite;
                r_wdata <= apb.pwdata;
            end
            if (w_commit && r_addr == A_TDR) r_tdr <= r_wdata;
            if (w_commit && r_addr == A_TCR) r_tcr <= r_wdata & 8'hB3;
            // A same-cycle event pulse overrides the write-one-to-clear.
            r_tsr <= (r_tsr & ~w_tsr_clr) | {udf_set, ovf_set};
        end
    end

    assign apb.prdata  = r_prdata;
    assign apb.pready  = r_pready;
    assign apb.pslverr = r_pslverr;
    assign tdr         = r_tdr;
    assign tcr_load    = r_tcr[7];
    assign tcr_cks     = r_tcr[5:4];
    assign tcr_dn      = r_tcr[1];
    assign tcr_en      = r_tcr[0];
    assign irq         = r_tsr[0] | r_tsr[1];
endmodule
